// File: rtl/text_console.sv
// text_console
//   Character-stream front end for the text display. Bytes arrive over a
//   valid/ready handshake and are turned into writes to the 40x30 character
//   RAM that the glyph renderer reads back. Handles LF, CR, BS, FF, line wrap
//   and hardware scroll. redraw pulses after every completed edit.
//
// Ports
//   pclk         in   pixel clock, the only clock
//   reset_n      in   asynchronous reset, active low
//   in_valid     in   in_data holds a byte
//   in_data      in   ASCII byte
//   in_ready     out  byte is taken on cycles with in_valid & in_ready
//   chr_wr       out  character RAM write strobe
//   chr_addr     out  character RAM write address
//   chr_data     out  character RAM write data
//   chr_rd_addr  out  character RAM read address (data returns next cycle)
//   chr_rd_data  in   read data for the previous cycle's chr_rd_addr
//   cur_col      out  cursor column
//   cur_row      out  cursor row
//   busy         out  clearing or scrolling
//   redraw       out  one-cycle pulse when an edit completes
//
// state       | meaning
// ------------+-----------------------------------------------------------
// CLEAR       | write BLANK to every cell, ascending, one per cycle
// IDLE        | accept and decode bytes from the stream
// SCROLL_COPY | move rows 1..ROWS-1 up one row through the RAM read port
// SCROLL_FILL | blank the last row

module text_console #(
    parameter int         COLS  = 40,
    parameter int         ROWS  = 30,
    parameter int         TOTAL = COLS * ROWS,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        chr_wr,
    output logic [10:0] chr_addr,
    output logic [7:0]  chr_data,
    output logic [10:0] chr_rd_addr,
    input  logic [7:0]  chr_rd_data,
    output logic [5:0]  cur_col,
    output logic [4:0]  cur_row,
    output logic        busy,
    output logic        redraw
);

    localparam logic [10:0] LAST_ADDR = 11'(TOTAL - 1);
    localparam logic [10:0] COPY_LEN  = 11'(TOTAL - COLS);
    localparam logic [10:0] COLS_A    = 11'(COLS);
    localparam logic [10:0] FILL_LAST = 11'(COLS - 1);
    localparam logic [5:0]  LAST_COL  = 6'(COLS - 1);
    localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        SCROLL_COPY,
        SCROLL_FILL
    } state_t;

    state_t      state;
    logic [10:0] cnt;
    logic        edit_pend;
    logic [10:0] cur_addr;
    logic        printable;

    assign cur_addr  = 11'(cur_row) * COLS_A + 11'(cur_col);
    assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= CLEAR;
            cnt         <= '0;
            edit_pend   <= 1'b0;
            in_ready    <= 1'b0;
            chr_wr      <= 1'b0;
            chr_addr    <= '0;
            chr_data    <= '0;
            chr_rd_addr <= '0;
            cur_col     <= '0;
            cur_row     <= '0;
            busy        <= 1'b0;
            redraw      <= 1'b0;
        end else begin
            chr_wr    <= 1'b0;
            edit_pend <= 1'b0;
            // edits redraw one cycle after their RAM write
            redraw    <= edit_pend;

            case (state)
                CLEAR: begin
                    busy     <= 1'b1;
                    chr_wr   <= 1'b1;
                    chr_addr <= cnt;
                    chr_data <= BLANK;
                    if (cnt == LAST_ADDR) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end

                IDLE: begin
                    if (!in_ready) begin
                        // first cycle back from CLEAR or a scroll
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        redraw   <= 1'b1;
                    end else if (in_valid) begin
                        if (printable) begin
                            chr_wr    <= 1'b1;
                            chr_addr  <= cur_addr;
                            chr_data  <= in_data;
                            edit_pend <= 1'b1;
                            if (cur_col != LAST_COL) begin
                                cur_col <= cur_col + 6'd1;
                            end else begin
                                cur_col <= '0;
                                if (cur_row != LAST_ROW) begin
                                    cur_row <= cur_row + 5'd1;
                                end else begin
                                    state    <= SCROLL_COPY;
                                    in_ready <= 1'b0;
                                    busy     <= 1'b1;
                                end
                            end
                        end else begin
                            case (in_data)
                                8'h0A: begin
                                    cur_col <= '0;
                                    if (cur_row != LAST_ROW) begin
                                        cur_row <= cur_row + 5'd1;
                                    end else begin
                                        state    <= SCROLL_COPY;
                                        in_ready <= 1'b0;
                                        busy     <= 1'b1;
                                    end
                                end
                                8'h0D: cur_col <= '0;
                                8'h08: begin
                                    if (cur_col != 6'd0) begin
                                        cur_col   <= cur_col - 6'd1;
                                        chr_wr    <= 1'b1;
                                        chr_addr  <= cur_addr - 11'd1;
                                        chr_data  <= BLANK;
                                        edit_pend <= 1'b1;
                                    end
                                end
                                8'h0C: begin
                                    state    <= CLEAR;
                                    cur_col  <= '0;
                                    cur_row  <= '0;
                                    in_ready <= 1'b0;
                                    busy     <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                SCROLL_COPY: begin
                    // cnt counts cycles in this state; reads run two cycles
                    // ahead of the writes they feed (address out, data back)
                    if (cnt < COPY_LEN) begin
                        chr_rd_addr <= cnt + COLS_A;
                    end
                    if (cnt >= 11'd2) begin
                        chr_wr   <= 1'b1;
                        chr_addr <= cnt - 11'd2;
                        chr_data <= chr_rd_data;
                    end
                    if (cnt == COPY_LEN + 11'd1) begin
                        cnt   <= '0;
                        state <= SCROLL_FILL;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end

                SCROLL_FILL: begin
                    chr_wr   <= 1'b1;
                    chr_addr <= COPY_LEN + cnt;
                    chr_data <= BLANK;
                    if (cnt == FILL_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end

                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_text_console.sv
module tb_text_console;

    localparam int COLS  = 40;
    localparam int ROWS  = 30;
    localparam int TOTAL = 1200;

    logic        pclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        chr_wr;
    logic [10:0] chr_addr;
    logic [7:0]  chr_data;
    logic [10:0] chr_rd_addr;
    logic [7:0]  chr_rd_data;
    logic [5:0]  cur_col;
    logic [4:0]  cur_row;
    logic        busy;
    logic        redraw;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ram     [0:TOTAL-1];
    logic [7:0] exp_ram [0:TOTAL-1];
    logic       preload = 1'b0;

    typedef struct {
        logic [7:0] b;
        logic       wr;
        int         addr;
        logic [7:0] data;
        int         col;
        int         row;
    } vec_t;

    vec_t tbl [11];

    text_console dut (
        .pclk        (pclk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .chr_wr      (chr_wr),
        .chr_addr    (chr_addr),
        .chr_data    (chr_data),
        .chr_rd_addr (chr_rd_addr),
        .chr_rd_data (chr_rd_data),
        .cur_col     (cur_col),
        .cur_row     (cur_row),
        .busy        (busy),
        .redraw      (redraw)
    );

    always #5 pclk = ~pclk;

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    // character RAM: synchronous write, one-cycle read latency
    always_ff @(posedge pclk) begin
        if (preload) begin
            for (int i = 0; i < TOTAL; i++) ram[i] <= pat(i);
        end else if (chr_wr) begin
            ram[chr_addr] <= chr_data;
        end
        chr_rd_data <= ram[chr_rd_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"},    int'(in_ready),    0);
        chk({tag, "_chr_wr"},      int'(chr_wr),      0);
        chk({tag, "_chr_addr"},    int'(chr_addr),    0);
        chk({tag, "_chr_data"},    int'(chr_data),    0);
        chk({tag, "_chr_rd_addr"}, int'(chr_rd_addr), 0);
        chk({tag, "_cur_col"},     int'(cur_col),     0);
        chk({tag, "_cur_row"},     int'(cur_row),     0);
        chk({tag, "_busy"},        int'(busy),        0);
        chk({tag, "_redraw"},      int'(redraw),      0);
    endtask

    task automatic compare_ram(input string tag);
        int bad = 0;
        for (int i = 0; i < TOTAL; i++) if (ram[i] !== exp_ram[i]) bad++;
        chk({tag, "_ram_cells_wrong"}, bad, 0);
    endtask

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [7:0] b);
        int t = 0;
        while (in_ready !== 1'b1 && t < 2000) begin
            @(negedge pclk);
            t++;
        end
        chk("send_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge pclk);
        in_valid = 1'b0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        send(v.b);
        chk({tag, "_wr"}, int'(chr_wr), int'(v.wr));
        if (v.wr) begin
            chk({tag, "_addr"}, int'(chr_addr), v.addr);
            chk({tag, "_data"}, int'(chr_data), int'(v.data));
            exp_ram[v.addr] = v.data;
        end
        chk({tag, "_col"}, int'(cur_col), v.col);
        chk({tag, "_row"}, int'(cur_row), v.row);
        @(negedge pclk);
        chk({tag, "_redraw"}, int'(redraw), int'(v.wr));
    endtask

    // first clear write must be visible at the current negedge
    task automatic check_clear(input string tag);
        int bad = 0;
        for (int k = 0; k < TOTAL; k++) begin
            if (chr_wr !== 1'b1 || chr_addr != 11'(k) || chr_data != 8'h20 ||
                busy !== 1'b1 || in_ready !== 1'b0 || redraw !== 1'b0) bad++;
            @(negedge pclk);
        end
        chk({tag, "_clear_seq_bad_cycles"}, bad, 0);
        chk({tag, "_clear_end_wr"},     int'(chr_wr),   0);
        chk({tag, "_clear_end_redraw"}, int'(redraw),   1);
        chk({tag, "_clear_end_ready"},  int'(in_ready), 1);
        chk({tag, "_clear_end_busy"},   int'(busy),     0);
        @(negedge pclk);
        chk({tag, "_clear_redraw_once"}, int'(redraw), 0);
        chk({tag, "_clear_col"}, int'(cur_col), 0);
        chk({tag, "_clear_row"}, int'(cur_row), 0);
        for (int i = 0; i < TOTAL; i++) exp_ram[i] = 8'h20;
        compare_ram(tag);
    endtask

    // called at the negedge after the byte that triggered the scroll (cycle 0)
    task automatic check_scroll(input string tag, input bit printable);
        logic [7:0] post [0:TOTAL-1];
        int bad_wr = 0, bad_rdy = 0, bad_rd = 0, bad_ra = 0;
        logic exp_wr, exp_rd;
        for (int i = 0; i < TOTAL; i++)
            post[i] = (i < TOTAL - COLS) ? exp_ram[i + COLS] : 8'h20;
        for (int n = 1; n <= 1203; n++) begin
            @(negedge pclk);
            exp_wr = (n >= 3 && n <= 1202);
            if (chr_wr !== exp_wr) bad_wr++;
            else if (exp_wr && (chr_addr != 11'(n - 3) || chr_data != post[n - 3])) bad_wr++;
            if (n <= 1160 && chr_rd_addr != 11'(39 + n)) bad_ra++;
            if (n > 1160 && chr_rd_addr != 11'(TOTAL - 1)) bad_ra++;
            if (n < 1203 && (in_ready !== 1'b0 || busy !== 1'b1)) bad_rdy++;
            exp_rd = (n == 1 && printable) || n == 1203;
            if (redraw !== exp_rd) bad_rd++;
        end
        chk({tag, "_scroll_write_bad_cycles"}, bad_wr, 0);
        chk({tag, "_scroll_rdaddr_bad_cycles"}, bad_ra, 0);
        chk({tag, "_scroll_ready_busy_bad_cycles"}, bad_rdy, 0);
        chk({tag, "_scroll_redraw_bad_cycles"}, bad_rd, 0);
        chk({tag, "_scroll_end_ready"}, int'(in_ready), 1);
        chk({tag, "_scroll_end_busy"},  int'(busy),     0);
        chk({tag, "_scroll_col"}, int'(cur_col), 0);
        chk({tag, "_scroll_row"}, int'(cur_row), ROWS - 1);
        for (int i = 0; i < TOTAL; i++) exp_ram[i] = post[i];
    endtask

    initial begin
        vec_t v;

        // after "AB" the cursor sits at (2,0)
        tbl[0]  = '{8'h0D, 1'b0, 0,  8'h00, 0, 0};
        tbl[1]  = '{8'h0A, 1'b0, 0,  8'h00, 0, 1};
        tbl[2]  = '{8'h43, 1'b1, 40, 8'h43, 1, 1};
        tbl[3]  = '{8'h08, 1'b1, 40, 8'h20, 0, 1};
        tbl[4]  = '{8'h08, 1'b0, 0,  8'h00, 0, 1};
        tbl[5]  = '{8'h07, 1'b0, 0,  8'h00, 0, 1};
        tbl[6]  = '{8'h7E, 1'b1, 40, 8'h7E, 1, 1};
        tbl[7]  = '{8'h7F, 1'b0, 0,  8'h00, 1, 1};
        tbl[8]  = '{8'h20, 1'b1, 41, 8'h20, 2, 1};
        tbl[9]  = '{8'h1F, 1'b0, 0,  8'h00, 2, 1};
        tbl[10] = '{8'h0A, 1'b0, 0,  8'h00, 0, 2};

        // reset values, then the power-on clear
        repeat (3) @(negedge pclk);
        check_zero("reset");
        reset_n = 1'b1;
        @(negedge pclk);
        check_clear("t1");

        // back-to-back "AB"
        chk("ab_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = 8'h41;
        @(negedge pclk);
        chk("ab_a_wr",   int'(chr_wr),   1);
        chk("ab_a_addr", int'(chr_addr), 0);
        chk("ab_a_data", int'(chr_data), 8'h41);
        chk("ab_ready_b", int'(in_ready), 1);
        in_data = 8'h42;
        @(negedge pclk);
        in_valid = 1'b0;
        chk("ab_b_wr",     int'(chr_wr),   1);
        chk("ab_b_addr",   int'(chr_addr), 1);
        chk("ab_b_data",   int'(chr_data), 8'h42);
        chk("ab_redraw_a", int'(redraw),   1);
        @(negedge pclk);
        chk("ab_redraw_b", int'(redraw), 1);
        chk("ab_idle_wr",  int'(chr_wr), 0);
        @(negedge pclk);
        chk("ab_redraw_off", int'(redraw), 0);
        chk("ab_col", int'(cur_col), 2);
        chk("ab_row", int'(cur_row), 0);
        exp_ram[0] = 8'h41;
        exp_ram[1] = 8'h42;

        for (int i = 0; i < 11; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // line wrap at column 39 of row 5, then BS at column 0
        for (int i = 0; i < 3; i++) apply('{8'h0A, 1'b0, 0, 8'h00, 0, 3 + i}, "lf_down");
        for (int i = 0; i < 39; i++) begin
            v = '{8'(97 + i % 26), 1'b1, 200 + i, 8'(97 + i % 26), i + 1, 5};
            apply(v, "row5_fill");
        end
        apply('{8'h58, 1'b1, 239, 8'h58, 0, 6}, "wrap_x");
        apply('{8'h08, 1'b0, 0, 8'h00, 0, 6}, "bs_col0");
        compare_ram("t3");

        // LF-triggered scroll over a preloaded screen
        for (int i = 0; i < 23; i++) apply('{8'h0A, 1'b0, 0, 8'h00, 0, 7 + i}, "lf_bottom");
        preload = 1'b1;
        @(negedge pclk);
        preload = 1'b0;
        for (int i = 0; i < TOTAL; i++) exp_ram[i] = pat(i);
        @(negedge pclk);
        send(8'h0A);
        chk("t4_lf_wr",    int'(chr_wr),   0);
        chk("t4_lf_ready", int'(in_ready), 0);
        chk("t4_lf_busy",  int'(busy),     1);
        check_scroll("t4", 1'b0);
        @(negedge pclk);
        compare_ram("t4");

        // wrap-triggered scroll with the next byte held waiting
        for (int i = 0; i < 39; i++) begin
            v = '{8'(48 + i % 10), 1'b1, 1160 + i, 8'(48 + i % 10), i + 1, 29};
            apply(v, "row29_fill");
        end
        send(8'h5A);
        chk("t5_z_wr",   int'(chr_wr),   1);
        chk("t5_z_addr", int'(chr_addr), 1199);
        chk("t5_z_data", int'(chr_data), 8'h5A);
        exp_ram[1199] = 8'h5A;
        in_valid = 1'b1;
        in_data  = 8'h41;
        check_scroll("t5", 1'b1);
        @(negedge pclk);
        in_valid = 1'b0;
        chk("t5_held_wr",   int'(chr_wr),   1);
        chk("t5_held_addr", int'(chr_addr), 1160);
        chk("t5_held_data", int'(chr_data), 8'h41);
        chk("t5_held_col",  int'(cur_col),  1);
        chk("t5_held_row",  int'(cur_row),  29);
        exp_ram[1160] = 8'h41;
        @(negedge pclk);
        chk("t5_held_redraw", int'(redraw), 1);
        compare_ram("t5");

        // reset during the copy phase, at the 500th copy write
        send(8'h0A);
        for (int n = 1; n <= 502; n++) @(negedge pclk);
        chk("t6_copy500_wr",   int'(chr_wr),   1);
        chk("t6_copy500_addr", int'(chr_addr), 499);
        reset_n = 1'b0;
        #1;
        check_zero("t6_async");
        @(negedge pclk);
        @(negedge pclk);
        check_zero("t6_held");
        reset_n = 1'b1;
        @(negedge pclk);
        check_clear("t6");

        // a write after the restart, then form feed
        apply('{8'h51, 1'b1, 0, 8'h51, 1, 0}, "post_reset_q");
        send(8'h0C);
        chk("ff_wr",    int'(chr_wr),   0);
        chk("ff_ready", int'(in_ready), 0);
        chk("ff_busy",  int'(busy),     1);
        chk("ff_col",   int'(cur_col),  0);
        chk("ff_row",   int'(cur_row),  0);
        @(negedge pclk);
        check_clear("ff");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
